// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock, MSB first
module seq_divider #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dividend_q;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W:0]    part;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  dbz_q;

    logic                  accept;
    logic                  last_step;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted   = {part[DIVISOR_W-1:0], dividend_q[cnt]};
        fits      = (shifted >= {1'b0, divisor_q});
        trial     = fits ? (shifted - {1'b0, divisor_q}) : shifted;
        last_step = (cnt == '0);
        accept    = (state == IDLE) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            part        <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            dividend_q  <= bus.dividend;
            divisor_q   <= bus.divisor;
            part        <= '0;
            cnt         <= CNT_W'(DIVIDEND_W - 1);
            remainder_q <= '0;
            // A zero divisor skips CALC and reports the saturated quotient at once.
            if (bus.divisor == '0) begin
                quotient_q <= '1;
                dbz_q      <= 1'b1;
            end else begin
                quotient_q <= '0;
                dbz_q      <= 1'b0;
            end
        end else if (state == CALC) begin
            part            <= trial;
            quotient_q[cnt] <= fits;
            if (last_step) begin
                remainder_q <= trial[DIVISOR_W-1:0];
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against a protocol-level reference model
module tb_seq_divider;
    localparam int W  = 6;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    seq_divider_if #(.DIVIDEND_W(W), .DIVISOR_W(DW)) dif ();

    seq_divider #(.DIVIDEND_W(W), .DIVISOR_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    // Reference model: expected handshake timing and held results, from edge count and operands.
    int m_q, m_r, m_dbz, m_valid;
    int m_done_at = -1;
    int m_busy_lo = 1;
    int m_busy_hi = 0;
    int m_free_at = 0;
    int m_pend = 0;
    int p_q, p_r;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_q = 0; m_r = 0; m_dbz = 0; m_valid = 1;
            m_done_at = -1; m_busy_lo = 1; m_busy_hi = 0;
            m_pend = 0; m_free_at = cyc + 1;
        end else begin
            if (m_pend != 0 && cyc == m_done_at) begin
                m_q = p_q; m_r = p_r; m_valid = 1; m_pend = 0;
            end
            if (dif.start === 1'b1 && cyc >= m_free_at) begin
                if (int'(dif.divisor) == 0) begin
                    m_q = (1 << W) - 1; m_r = 0; m_dbz = 1; m_valid = 1;
                    m_done_at = cyc;
                end else begin
                    p_q = int'(dif.dividend) / int'(dif.divisor);
                    p_r = int'(dif.dividend) % int'(dif.divisor);
                    m_pend = 1; m_dbz = 0; m_valid = 0;
                    m_busy_lo = cyc; m_busy_hi = cyc + W - 1;
                    m_done_at = cyc + W;
                end
                m_free_at = m_done_at + 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at cycle %0d: got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 3 * W; i++) begin
            if (dif.done === 1'b1) begin
                d = cyc;
                break;
            end
            @(negedge clk);
        end
        if (d < 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL done_timeout at cycle %0d: got=no done expected=done within %0d cycles", cyc, 3 * W);
        end
    endtask

    task automatic run(input int dd, input int dv, output int t, output int d);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = W'(dd);
        dif.divisor  = DW'(dv);
        t = cyc + 1;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(d);
    endtask

    int t, d, t1, d1, d2;

    initial begin
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        fork
            forever begin
                @(negedge clk);
                if (cyc >= 1) begin
                    chk("done", 32'(dif.done), 32'(cyc == m_done_at));
                    chk("busy", 32'(dif.busy), 32'(cyc >= m_busy_lo && cyc <= m_busy_hi));
                    chk("div_by_zero", 32'(dif.div_by_zero), 32'(m_dbz));
                    if (m_valid != 0) begin
                        chk("quotient", 32'(dif.quotient), 32'(m_q));
                        chk("remainder", 32'(dif.remainder), 32'(m_r));
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(dif.busy), 0);
        chk("rst_done", 32'(dif.done), 0);
        chk("rst_quotient", 32'(dif.quotient), 0);
        chk("rst_remainder", 32'(dif.remainder), 0);
        chk("rst_dbz", 32'(dif.div_by_zero), 0);
        repeat (5) @(negedge clk);

        run(42, 5, t, d);
        chk("lat_42_5", 32'(d - t), 6);
        chk("q_42_5", 32'(dif.quotient), 8);
        chk("r_42_5", 32'(dif.remainder), 2);
        chk("dbz_42_5", 32'(dif.div_by_zero), 0);

        for (int dd = 0; dd < (1 << W); dd++) begin
            for (int dv = 1; dv < (1 << DW); dv++) begin
                run(dd, dv, t, d);
                chk("inv_product", 32'(int'(dif.quotient) * dv + int'(dif.remainder)), 32'(dd));
                chk("inv_rem_lt", 32'(int'(dif.remainder) < dv), 1);
                if (dd == 63 && dv == 1) begin
                    chk("q_63_1", 32'(dif.quotient), 63);
                    chk("r_63_1", 32'(dif.remainder), 0);
                end
                if (dd == 49 && dv == 7) begin
                    chk("q_49_7", 32'(dif.quotient), 7);
                    chk("r_49_7", 32'(dif.remainder), 0);
                end
            end
        end

        run(17, 0, t, d);
        chk("lat_div0", 32'(d - t), 0);
        chk("q_div0", 32'(dif.quotient), 63);
        chk("r_div0", 32'(dif.remainder), 0);
        chk("dbz_div0", 32'(dif.div_by_zero), 1);

        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = W'(50);
        dif.divisor  = DW'(6);
        t1 = cyc + 1;
        @(negedge clk);
        dif.dividend = W'(20);
        dif.divisor  = DW'(3);
        wait_done(d1);
        chk("lat_held", 32'(d1 - t1), 6);
        chk("q_50_6", 32'(dif.quotient), 8);
        chk("r_50_6", 32'(dif.remainder), 2);
        @(negedge clk);
        chk("held_idle_busy", 32'(dif.busy), 0);
        @(negedge clk);
        chk("held_reaccept_busy", 32'(dif.busy), 1);
        wait_done(d2);
        dif.start = 1'b0;
        chk("done_spacing", 32'(d2 - d1), 8);
        chk("q_20_3", 32'(dif.quotient), 6);
        chk("r_20_3", 32'(dif.remainder), 2);

        @(negedge clk);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = W'(45);
        dif.divisor  = DW'(4);
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(dif.busy), 0);
        chk("abort_done", 32'(dif.done), 0);
        chk("abort_quotient", 32'(dif.quotient), 0);
        chk("abort_remainder", 32'(dif.remainder), 0);
        chk("abort_dbz", 32'(dif.div_by_zero), 0);
        repeat (10) @(negedge clk);

        run(10, 3, t, d);
        chk("lat_10_3", 32'(d - t), 6);
        chk("q_10_3", 32'(dif.quotient), 3);
        chk("r_10_3", 32'(dif.remainder), 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
